// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (one bit per cycle) and MTHI/MTLO (single edge).
// Signed operations run on magnitudes; the sign is restored in the FINISH state.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_x,
  input  logic [2:0]       op_x,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] b_x,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // |multiplicand| or |divisor|
  logic [WIDTH-1:0]     araw_q, araw_d;   // dividend as issued, for divide-by-zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 div_q, div_d;
  logic                 neg_q, neg_d;     // negate product / quotient
  logic                 rneg_q, rneg_d;   // negate remainder
  logic                 dz_q, dz_d;       // divisor was zero
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return {WIDTH{1'b0}} - v;
  endfunction

  // Issue decode: operand magnitudes and sign flags.
  logic             md_op_s;
  logic             sgn_op_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;

  assign md_op_s  = ~op_x[2];
  assign sgn_op_s = ~op_x[0];
  assign a_neg_s  = sgn_op_s & a_x[WIDTH-1];
  assign b_neg_s  = sgn_op_s & b_x[WIDTH-1];
  assign a_abs_s  = a_neg_s ? neg_w(a_x) : a_x;
  assign b_abs_s  = b_neg_s ? neg_w(b_x) : b_x;

  // One iteration step of shift-add multiply and restoring divide.
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH-1:0] div_sub_s;
  logic [WIDTH-1:0] div_rem_s;
  logic             div_ge_s;

  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
  // When div_ge_s holds the difference is below 2^WIDTH, so the low bits suffice.
  assign div_sub_s   = div_shift_s[WIDTH-1:0] - opnd_q;
  assign div_rem_s   = div_ge_s ? div_sub_s : div_shift_s[WIDTH-1:0];

  // Sign fixup applied at FINISH.
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  assign prod_fix_s = neg_q  ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
  assign quo_fix_s  = neg_q  ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix_s  = rneg_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_x && md_op_s) begin
          state_d = S_RUN;
          cnt_d   = {CW{1'b0}};
          div_d   = op_x[1];
          neg_d   = a_neg_s ^ b_neg_s;
          rneg_d  = a_neg_s;
          dz_d    = (b_x == {WIDTH{1'b0}});
          araw_d  = a_x;
          opnd_d  = op_x[1] ? b_abs_s : a_abs_s;
          acc_d   = {{WIDTH{1'b0}}, (op_x[1] ? a_abs_s : b_abs_s)};
        end else if (start_x && (op_x == OP_MTHI)) begin
          hi_d = a_x;
        end else if (start_x && (op_x == OP_MTLO)) begin
          lo_d = a_x;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (div_q) begin
            acc_d = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};
          end else begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (div_q && dz_q) begin
            lo_d  = {WIDTH{1'b1}};
            hi_d  = araw_q;
            dbz_d = 1'b1;
          end else if (div_q) begin
            lo_d = quo_fix_s;
            hi_d = rem_fix_s;
          end else begin
            {hi_d, lo_d} = prod_fix_s;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      opnd_q  <= {WIDTH{1'b0}};
      araw_q  <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: a 32-bit and an 8-bit instance,
// directed cases plus random operations checked against an arithmetic model.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_x;
  logic        abort;
  logic        use8;
  logic [2:0]  op_x;
  logic [31:0] a_x;
  logic [31:0] b_x;

  logic [31:0] hi32, lo32;
  logic        busy32, done32, dbz32;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8, dbz8;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] hm [2];
  logic [31:0] lm [2];

  mips_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start_x(start_x & ~use8), .op_x(op_x),
    .a_x(a_x), .b_x(b_x), .abort(abort & ~use8),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_x(start_x & use8), .op_x(op_x),
    .a_x(a_x[7:0]), .b_x(b_x[7:0]), .abort(abort & use8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  logic [31:0] cur_hi, cur_lo;
  logic        cur_busy, cur_done, cur_dbz;
  assign cur_hi   = use8 ? {24'd0, hi8} : hi32;
  assign cur_lo   = use8 ? {24'd0, lo8} : lo32;
  assign cur_busy = use8 ? busy8 : busy32;
  assign cur_done = use8 ? done8 : done32;
  assign cur_dbz  = use8 ? dbz8  : dbz32;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Architectural result of one operation, from plain integer arithmetic.
  task automatic model(input int w, input logic [2:0] op,
                       input logic [31:0] a_in, input logic [31:0] b_in,
                       input logic [31:0] hi_in, input logic [31:0] lo_in,
                       output logic [31:0] eh, output logic [31:0] el,
                       output bit edz, output bit lng);
    longint      m, sa, sb, r;
    logic [31:0] a, b;
    m  = (longint'(1) << w) - 1;
    a  = a_in & 32'(m);
    b  = b_in & 32'(m);
    sa = longint'(a);
    sb = longint'(b);
    if (!op[0] && a[w-1]) sa = sa - (longint'(1) << w);
    if (!op[0] && b[w-1]) sb = sb - (longint'(1) << w);
    eh  = hi_in;
    el  = lo_in;
    edz = 1'b0;
    lng = (op[2] == 1'b0);
    case (op)
      3'd0, 3'd1: begin
        r  = sa * sb;
        el = 32'(r & m);
        eh = 32'((r >> w) & m);
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          edz = 1'b1;
          el  = 32'(m);
          eh  = a;
        end else begin
          el = 32'((sa / sb) & m);
          eh = 32'((sa % sb) & m);
        end
      end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rnd_val(input int w);
    logic [31:0] msk, v;
    msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = msk;
      2: v = 32'd1 << (w - 1);
      3: v = 32'($urandom_range(0, 9));
      default: v = $urandom;
    endcase
    return v & msk;
  endfunction

  // Issue one op in the current cycle (caller sits at a negedge) and follow it
  // to completion. poke_at/abort_at (0 = off) name the busy cycle in which a
  // stray start_x or an abort is driven.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int abort_at);
    int          w, n, k;
    logic [31:0] eh, el;
    bit          edz, lng;
    k = use8 ? 1 : 0;
    w = use8 ? 8 : 32;
    model(w, op, a, b, hm[k], lm[k], eh, el, edz, lng);
    start_x = 1'b1; op_x = op; a_x = a; b_x = b;
    @(negedge clk);
    start_x = 1'b0; a_x = $urandom; b_x = $urandom; op_x = 3'($urandom);
    if (!lng) begin
      check_val("short_busy", 32'(cur_busy), 32'd0);
      check_val("short_done", 32'(cur_done), 32'd0);
      check_val("short_hi", cur_hi, eh);
      check_val("short_lo", cur_lo, el);
      hm[k] = eh;
      lm[k] = el;
    end else begin
      n = 0;
      while (cur_busy && n < 100) begin
        n++;
        if (n == 1) begin
          check_val("done_width", 32'(cur_done), 32'd0);
          check_val("dbz_width", 32'(cur_dbz), 32'd0);
        end
        check_val("hold_hi", cur_hi, hm[k]);
        check_val("hold_lo", cur_lo, lm[k]);
        if (n == poke_at) begin
          start_x = 1'b1; op_x = 3'b100; a_x = 32'h0000_00A5;
        end
        if (n == abort_at) abort = 1'b1;
        @(negedge clk);
        start_x = 1'b0;
        abort   = 1'b0;
      end
      if (abort_at > 0) begin
        check_val("abort_len", n, abort_at);
        check_val("abort_done", 32'(cur_done), 32'd0);
        check_val("abort_hi", cur_hi, hm[k]);
        check_val("abort_lo", cur_lo, lm[k]);
      end else begin
        check_val("busy_len", n, w + 1);
        check_val("done", 32'(cur_done), 32'd1);
        check_val("div_by_zero", 32'(cur_dbz), 32'(edz));
        check_val("hi", cur_hi, eh);
        check_val("lo", cur_lo, el);
        hm[k] = eh;
        lm[k] = el;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_x = 1'b0; abort = 1'b0; use8 = 1'b0;
    op_x = 3'd0; a_x = 32'd0; b_x = 32'd0;
    hm[0] = 32'd0; hm[1] = 32'd0; lm[0] = 32'd0; lm[1] = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("rst_hi", hi32, 32'd0);
    check_val("rst_lo", lo32, 32'd0);
    check_val("rst_busy", 32'(busy32), 32'd0);
    check_val("rst_done", 32'(done32), 32'd0);
    check_val("rst_dbz", 32'(dbz32), 32'd0);
    check_val("rst_hi8", {24'd0, hi8}, 32'd0);

    // Directed 32-bit cases.
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    check_val("mult_m3x7_hi", cur_hi, 32'hFFFF_FFFF);
    check_val("mult_m3x7_lo", cur_lo, 32'hFFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check_val("multu_max_hi", cur_hi, 32'hFFFF_FFFE);
    check_val("multu_max_lo", cur_lo, 32'h0000_0001);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check_val("div_m7_2_lo", cur_lo, 32'hFFFF_FFFD);
    check_val("div_m7_2_hi", cur_hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd7, 32'd2, 0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check_val("div_ovf_lo", cur_lo, 32'h8000_0000);
    run_op(3'd3, 32'd100, 32'd0, 0, 0);
    check_val("divu_0_hi", cur_hi, 32'd100);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, 0, 0);
    run_op(3'd4, 32'h0000_1234, 32'd0, 0, 0);
    run_op(3'd5, 32'h0000_5678, 32'd0, 0, 0);
    run_op(3'd0, 32'd3, 32'd4, 5, 10);
    check_val("abort_keep_hi", cur_hi, 32'h0000_1234);
    check_val("abort_keep_lo", cur_lo, 32'h0000_5678);
    run_op(3'd1, 32'd9, 32'd9, 0, 33);
    run_op(3'd6, 32'hAAAA_AAAA, 32'd1, 0, 0);
    run_op(3'd7, 32'h5555_5555, 32'd1, 0, 0);

    // Random 32-bit operations.
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_val(32), rnd_val(32), 0,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 33)) : 0);
    end

    // Reset in the middle of a divide.
    start_x = 1'b1; op_x = 3'd2; a_x = 32'd12345; b_x = 32'd7;
    @(negedge clk);
    start_x = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_hi", hi32, 32'd0);
    check_val("mid_rst_lo", lo32, 32'd0);
    check_val("mid_rst_busy", 32'(busy32), 32'd0);
    check_val("mid_rst_done", 32'(done32), 32'd0);
    hm[0] = 32'd0; lm[0] = 32'd0; hm[1] = 32'd0; lm[1] = 32'd0;
    run_op(3'd3, 32'd50, 32'd8, 0, 0);

    // 8-bit instance.
    use8 = 1'b1;
    run_op(3'd0, 32'h80, 32'h80, 0, 0);
    check_val("w8_mult_hi", cur_hi, 32'h40);
    check_val("w8_mult_lo", cur_lo, 32'h00);
    for (int i = 0; i < 25; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_val(8), rnd_val(8), 0,
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 9)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
